// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle ops and an iterative 1-bit/cycle shifter.
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5,
   parameter int TAG_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_op,
   input  logic [XLEN-1:0]    in_a,
   input  logic [XLEN-1:0]    in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_result,
   output logic               out_zero,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
   state_t state, state_n;
   logic [3:0]         op_q;
   logic [SHAMT_W-1:0] cnt;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    alu_res;
   logic [XLEN-1:0]    shifted;
   logic               accept;
   logic               is_shift;
   assign shamt     = in_b[SHAMT_W-1:0];
   assign in_ready  = !rst && !flush && (state == IDLE || (state == HOLD && out_ready));
   assign accept    = in_valid && in_ready;
   assign is_shift  = in_op == 4'd6 || in_op == 4'd7 || in_op == 4'd8;
   assign out_valid = state == HOLD;
   assign busy      = state == SHIFT;
   assign out_zero  = out_result == '0;
   // Shift ops load operand A unshifted; the SHIFT state walks it one bit per cycle.
   always_comb begin
      case (in_op)
         4'd1:                alu_res = in_a + in_b;
         4'd2:                alu_res = in_a - in_b;
         4'd3:                alu_res = in_a & in_b;
         4'd4:                alu_res = in_a | in_b;
         4'd5:                alu_res = in_a ^ in_b;
         4'd6, 4'd7, 4'd8:    alu_res = in_a;
         4'd9:                alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
         4'd10:               alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
         default:             alu_res = '0;
      endcase
   end
   assign shifted = (op_q == 4'd6) ? {out_result[XLEN-2:0], 1'b0}
                                   : {(op_q == 4'd7) ? out_result[XLEN-1] : 1'b0, out_result[XLEN-1:1]};
   always_comb begin
      state_n = state;
      if (flush)
         state_n = IDLE;
      else if (accept)
         state_n = (is_shift && shamt != '0) ? SHIFT : HOLD;
      else if (state == SHIFT && cnt == SHAMT_W'(1))
         state_n = HOLD;
      else if (state == HOLD && out_ready)
         state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_result <= '0;
         out_tag    <= '0;
         op_q       <= '0;
         cnt        <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept) begin
         out_result <= alu_res;
         out_tag    <= in_tag;
         op_q       <= in_op;
         cnt        <= is_shift ? shamt : '0;
      end else if (state == SHIFT) begin
         out_result <= shifted;
         cnt        <= cnt - SHAMT_W'(1);
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, busy;
   logic [3:0]  in_op;
   logic [31:0] in_a, in_b, out_result;
   logic [4:0]  in_tag, out_tag;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .SHAMT_W(5), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
      .out_tag(out_tag), .busy(busy)
   );

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh = int'(b[4:0]);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return a << sh;
         4'd7:    return $signed(a) >>> sh;
         4'd8:    return a >> sh;
         4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd10:   return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
      return (op >= 4'd6 && op <= 4'd8) ? int'(b[4:0]) + 1 : 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 64) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
      step(); step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", out_result); end
      checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_add();
      send(4'd1, 32'd5, 32'd7, 5'd3);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
      checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result got=%h exp=c", out_result); end
      checks++; if (out_tag !== 5'd3) begin errors++; $display("FAIL add_tag got=%h exp=3", out_tag); end
      checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b exp=0", out_zero); end
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_idle valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
   endtask

   task automatic test_directed_arith();
      logic [3:0]  ops [4] = '{4'd2, 4'd2, 4'd9, 4'd10};
      logic [31:0] as  [4] = '{32'd3, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs  [4] = '{32'd5, 32'd9, 32'd1, 32'd1};
      logic [31:0] exp [4] = '{32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0};
      int lat;
      for (int i = 0; i < 4; i++) begin
         send(ops[i], as[i], bs[i], 5'(i + 10));
         wait_out(lat);
         checks++; if (lat !== 1) begin errors++; $display("FAIL arith%0d_latency got=%0d exp=1", i, lat); end
         checks++; if (out_result !== exp[i]) begin errors++; $display("FAIL arith%0d_result got=%h exp=%h", i, out_result, exp[i]); end
         checks++; if (out_zero !== (exp[i] == 32'd0)) begin errors++; $display("FAIL arith%0d_zero got=%b exp=%b", i, out_zero, exp[i] == 32'd0); end
         step();
      end
   endtask

   task automatic test_shift();
      int lat;
      send(4'd7, 32'h8000_0000, 32'h24, 5'd6);
      for (int i = 1; i <= 4; i++) begin
         checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL sra_busy_cycle%0d busy=%b ready=%b valid=%b exp 1/0/0", i, busy, in_ready, out_valid);
         end
         step();
      end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sra_done valid=%b busy=%b exp 1/0", out_valid, busy); end
      checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result got=%h exp=f8000000", out_result); end
      step();
      send(4'd8, 32'h8000_0000, 32'h24, 5'd7);
      wait_out(lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL srl_latency got=%0d exp=5", lat); end
      checks++; if (out_result !== 32'h0800_0000) begin errors++; $display("FAIL srl_result got=%h exp=08000000", out_result); end
      step();
      send(4'd6, 32'd1, 32'd0, 5'd8);
      wait_out(lat);
      checks++; if (lat !== 1 || out_result !== 32'd1) begin errors++; $display("FAIL sll0 lat=%0d result=%h exp lat=1 result=1", lat, out_result); end
      step();
      send(4'd6, 32'hDEAD_BEEF, 32'hFFFF_FFDF, 5'd9);
      wait_out(lat);
      checks++; if (lat !== 32 || out_result !== 32'h8000_0000) begin errors++; $display("FAIL sll31 lat=%0d result=%h exp lat=32 result=80000000", lat, out_result); end
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      send(4'd1, 32'd10, 32'd20, 5'd7);
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1 || out_result !== 32'd30 || out_tag !== 5'd7 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold%0d valid=%b result=%h tag=%h ready=%b exp 1/1e/7/0", i, out_valid, out_result, out_tag, in_ready);
         end
         step();
      end
      out_ready = 1'b1; in_valid = 1'b1; in_op = 4'd5; in_a = 32'hF0; in_b = 32'hFF; in_tag = 5'd9;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h0F || out_tag !== 5'd9) begin
         errors++; $display("FAIL b2b_xor valid=%b result=%h tag=%h exp 1/f/9", out_valid, out_result, out_tag);
      end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle valid=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      int lat;
      send(4'd6, 32'd3, 32'd10, 5'd2);
      step();
      flush = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_a = 32'd50; in_b = 32'd50; in_tag = 5'd1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_idle valid=%b busy=%b ready=%b exp 0/0/1", out_valid, busy, in_ready);
      end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept valid=%b exp=0", out_valid); end
      send(4'd1, 32'd1, 32'd1, 5'd4);
      wait_out(lat);
      checks++; if (lat !== 1 || out_result !== 32'd2 || out_tag !== 5'd4) begin
         errors++; $display("FAIL flush_add lat=%0d result=%h tag=%h exp 1/2/4", lat, out_result, out_tag);
      end
      step();
   endtask

   task automatic test_rst_hold();
      out_ready = 1'b0;
      send(4'd1, 32'd4, 32'd4, 5'd5);
      rst = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_a = 32'd7; in_b = 32'd7; in_tag = 5'd11;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_hold valid=%b result=%h tag=%h ready=%b exp 0/0/0/1", out_valid, out_result, out_tag, in_ready);
      end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_accept valid=%b exp=0", out_valid); end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b, exp;
      logic [4:0]  tag;
      int lat;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; tag = 5'($urandom);
         if (i % 5 == 0) b[4:0] = 5'd0;
         exp = ref_alu(op, a, b);
         send(op, a, b, tag);
         wait_out(lat);
         checks++; if (lat !== ref_lat(op, b) || out_result !== exp || out_tag !== tag || out_zero !== (exp == 32'd0)) begin
            errors++; $display("FAIL rand%0d op=%0d a=%h b=%h lat=%0d result=%h tag=%h zero=%b exp lat=%0d result=%h tag=%h",
                               i, op, a, b, lat, out_result, out_tag, out_zero, ref_lat(op, b), exp, tag);
         end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_directed_arith();
      test_shift();
      test_back_to_back();
      test_flush();
      test_rst_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
